// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment display arbiter.
//   - digit codes for the non-numeric glyphs
//   - arbiter state encoding
//   - active-low segment patterns, bit 0 = segment a ... bit 6 = segment g
package seg7_pkg;

    localparam logic [3:0] DIGIT_A     = 4'd10;
    localparam logic [3:0] DIGIT_L     = 4'd11;
    localparam logic [3:0] DIGIT_O     = 4'd12;
    localparam logic [3:0] DIGIT_H     = 4'd13;
    localparam logic [3:0] DIGIT_DASH  = 4'd14;
    localparam logic [3:0] DIGIT_BLANK = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } arb_state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_H     = 7'h09;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational digit code to active-low segment pattern.
// Ports:
//   i_code   [3:0] digit code (0-9, A, L, O, H, dash, blank)
//   o_seg_c  [6:0] active-low segments, bit 0 = a ... bit 6 = g
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        case (i_code)
            4'd0:        o_seg_c = SEG_0;
            4'd1:        o_seg_c = SEG_1;
            4'd2:        o_seg_c = SEG_2;
            4'd3:        o_seg_c = SEG_3;
            4'd4:        o_seg_c = SEG_4;
            4'd5:        o_seg_c = SEG_5;
            4'd6:        o_seg_c = SEG_6;
            4'd7:        o_seg_c = SEG_7;
            4'd8:        o_seg_c = SEG_8;
            4'd9:        o_seg_c = SEG_9;
            DIGIT_A:     o_seg_c = SEG_A;
            DIGIT_L:     o_seg_c = SEG_L;
            DIGIT_O:     o_seg_c = SEG_O;
            DIGIT_H:     o_seg_c = SEG_H;
            DIGIT_DASH:  o_seg_c = SEG_DASH;
            default:     o_seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: grants the 8-digit seven-segment display to one of
// NUM_REQ clients with a minimum hold time, buffers the owner's frame and
// drives the multiplexed digit scan.
// Optional feature: SEG7_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default build is fixed priority, lowest index wins).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req     [N-1:0]   per-client request levels
//   frame   [N*32-1:0] per-client digit codes, digit k at [4k+3:4k]
//   dp_mask [N*8-1:0] per-client decimal-point enables
//   grant   [N-1:0]   one-hot owner, zero when idle
//   busy              any client owns the display
//   SEG[6:0], DP, AN[7:0]  active-low display pins (registered)
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MIN_HOLD_CYCLES = 50_000_000,
    parameter int unsigned SCAN_BITS       = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*32-1:0] frame,
    input  logic [NUM_REQ*8-1:0] dp_mask,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [6:0]           SEG,
    output logic                 DP,
    output logic [7:0]           AN
);

    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned HOLD_W    = (MIN_HOLD_CYCLES == 0) ? 1 : $clog2(MIN_HOLD_CYCLES + 1);
    // A zero hold still spends one cycle in HOLD (counter value 0).
    localparam int unsigned HOLD_LAST = (MIN_HOLD_CYCLES == 0) ? 0 : MIN_HOLD_CYCLES - 1;

    arb_state_e           r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]     r_owner;
    logic                 r_busy;
    logic [HOLD_W-1:0]    r_hold, w_hold_nxt;
    logic [SCAN_BITS-1:0] r_refresh;
    logic [7:0][3:0]      r_digits;
    logic [7:0]           r_buf_dp;
    logic [6:0]           r_seg;
    logic                 r_dp_pin;
    logic [7:0]           r_an;

    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_win_vld;
    logic                 w_take;
    logic                 w_release;
    logic [31:0]          w_own_frame;
    logic [7:0]           w_own_dp;
    logic [2:0]           w_digit;
    logic [6:0]           w_seg_dec;

`ifdef SEG7_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     r_last;

    // Rotating search from the slot after the last owner; the loop runs
    // farthest-first so the nearest requester overwrites the result.
    always_comb begin
        w_win_idx = '0;
        w_win_vld = 1'b0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            if (req[IDX_W'((int'(r_last) + k) % int'(NUM_REQ))]) begin
                w_win_idx = IDX_W'((int'(r_last) + k) % int'(NUM_REQ));
                w_win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if (w_take) begin
            r_last <= w_win_idx;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        w_win_idx = '0;
        w_win_vld = 1'b0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (req[IDX_W'(k)]) begin
                w_win_idx = IDX_W'(k);
                w_win_vld = 1'b1;
            end
        end
    end
`endif

    // Next-state logic. While the owner keeps requesting, the winner can only
    // differ from the owner if someone ahead of it (priority or rotation) asks.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_take      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!req[r_owner]) begin
                    w_release = 1'b1;
                end else if (r_hold == HOLD_W'(HOLD_LAST)) begin
                    w_state_nxt = ST_OPEN;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            ST_OPEN: begin
                if (!req[r_owner]) begin
                    w_release = 1'b1;
                end else if (w_win_vld && (w_win_idx != r_owner)) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Release hands over directly when someone else is waiting.
        if (w_release) begin
            if (w_win_vld) begin
                w_take      = 1'b1;
                w_state_nxt = ST_HOLD;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Current owner's frame and dp mask.
    always_comb begin
        w_own_frame = frame[31:0];
        w_own_dp    = dp_mask[7:0];
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (r_owner == IDX_W'(k)) begin
                w_own_frame = frame[k*32 +: 32];
                w_own_dp    = dp_mask[k*8 +: 8];
            end
        end
    end

    // Arbiter state, grant and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_owner <= w_win_idx;
                r_grant <= NUM_REQ'(1) << w_win_idx;
                r_busy  <= 1'b1;
                r_hold  <= '0;
            end else if (w_state_nxt == ST_IDLE) begin
                r_grant <= '0;
                r_busy  <= 1'b0;
                r_hold  <= '0;
            end else begin
                r_hold  <= w_hold_nxt;
            end
        end
    end

    // Frame buffer: blanked as the arbiter goes idle, else tracks the owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= {8{DIGIT_BLANK}};
            r_buf_dp <= '0;
        end else if (w_state_nxt == ST_IDLE) begin
            r_digits <= {8{DIGIT_BLANK}};
            r_buf_dp <= '0;
        end else if (|r_grant) begin
            r_digits <= w_own_frame;
            r_buf_dp <= w_own_dp;
        end
    end

    assign w_digit = r_refresh[SCAN_BITS-1 -: 3];

    seg7_decoder u_decoder (
        .i_code  (r_digits[w_digit]),
        .o_seg_c (w_seg_dec)
    );

    // Free-running scan and registered pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_seg     <= SEG_BLANK;
            r_dp_pin  <= 1'b1;
            r_an      <= 8'hFF;
        end else begin
            r_refresh <= r_refresh + SCAN_BITS'(1);
            r_seg     <= w_seg_dec;
            r_dp_pin  <= ~r_buf_dp[w_digit];
            r_an      <= ~(8'd1 << w_digit);
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;
    assign SEG   = r_seg;
    assign DP    = r_dp_pin;
    assign AN    = r_an;

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Shares the board's 8-digit seven-segment display between up to NUM_REQ independent display clients, such as the reaction-time readout, game banners and penalty/timeout messages. Each client supplies its own 8-digit frame and requests the display. The arbiter grants one owner at a time and enforces a minimum hold time before another client can preempt it. It also performs the multiplexed digit scan and segment decode, and drives the SEG/DP/AN pins directly.

## Interface
- NUM_REQ, 4, number of clients (2..8)
- MIN_HOLD_CYCLES, 50_000_000, cycles an owner keeps the display before it can be preempted (0.5 s at 100 MHz)
- SCAN_BITS, 20, width of the refresh counter; the digit index is refresh[SCAN_BITS-1:SCAN_BITS-3]
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-client request level, held high while the client wants the display
- frame  in  NUM_REQ x 32  per-client digit codes, packed; digit k is [4k+3:4k]; digit 0 is rightmost
- dp_mask  in  NUM_REQ x 8  per-client decimal-point enables, active high, one bit per digit
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle
- busy  out  1  high when any client owns the display
- SEG  out  7  segments a–g, active low
- DP  out  1  decimal point, active low
- AN  out  8  digit enables, active low

## Operation
- The arbiter FSM has three states: IDLE, HOLD and OPEN.
- IDLE:
  - grant is 0 and the display shows blank (all SEG bits = 1, DP = 1); the scan continues.
  - Any req bit set → grant the winner and move to HOLD. The hold counter loads 0.
- HOLD:
  - The hold counter increments each cycle.
  - Owner req low → release (see the release rule below).
  - Hold counter reaches MIN_HOLD_CYCLES-1 → move to OPEN.
  - Requests from other clients are ignored in HOLD.
- OPEN:
  - Owner req low → release.
  - Another client wins arbitration → switch grant to it, clear the hold counter, move to HOLD.
  - Otherwise stay in OPEN indefinitely.
- Release rule:
  - If any other req is high in the same cycle, grant the winner directly and go to HOLD, with no blank gap.
  - Otherwise go to IDLE.
- Winner selection (default): fixed priority, lowest index wins.
  - In OPEN, only a client with a lower index than the owner preempts.
- Frame buffer:
  - An 8×4 digit register plus an 8-bit dp register.
  - While a client is granted, the buffer loads that client's frame and dp_mask every cycle.
  - Cleared to blank code 15 and dp 0 on entry to IDLE.
- Digit codes: 0–9 numerals, 10 = A, 11 = L, 12 = O, 13 = H, 14 = dash (segment g only), 15 = blank.
- Scan:
  - The refresh counter free-runs and wraps at 2^SCAN_BITS.
  - The digit index d is the top 3 bits of the counter.
  - AN = ~(1<<d), SEG = decode(buffer[d]), DP = ~dp[d].

## Timing
- Reset values:
  - grant = 0, busy = 0, state IDLE, refresh counter 0, buffer blank.
  - SEG = 7'h7F, DP = 1, AN = 8'hFF.
- Reset asserted mid-operation returns the block to IDLE immediately; there is no wait for the hold to expire.
- Grant latency: a req rising in cycle N gives grant/busy in cycle N+1. The buffer holds the new frame in cycle N+2.
- Pin outputs are registered: SEG, DP and AN change one cycle after the buffer or the digit index changes.
- Each digit is lit for 2^(SCAN_BITS-3) cycles (1.31 ms at default settings); the full refresh is about 95 Hz.
- grant is always one-hot or zero, and it changes only on arbitration edges.
- Hold counter width is $clog2(MIN_HOLD_CYCLES+1). With MIN_HOLD_CYCLES = 0, HOLD lasts one cycle.
- A client whose req toggles while not granted has no effect; no request is latched.

## Configuration
- SEG7_ARB_ROUND_ROBIN_EN defined: winner selection is round-robin.
  - The search starts at the index after the most recent owner and wraps modulo NUM_REQ.
  - In OPEN, any other pending client preempts in rotation order.
  - The last-owner pointer resets to NUM_REQ-1, so client 0 is first after reset.
- SEG7_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins, as described under Operation.

## Structure
- seg7_pkg: digit-code localparams (DIGIT_A, DIGIT_L, DIGIT_O, DIGIT_H, DIGIT_DASH, DIGIT_BLANK), the arbiter state enum typedef, and the segment pattern constants.
- Sub-module seg7_decoder: combinational 4-bit code → 7-bit active-low pattern. Unknown codes map to blank.
- The arbiter FSM, frame buffer and scan counter live in seg7_display_arbiter.

## Test plan
Benches use SCAN_BITS = 6 and MIN_HOLD_CYCLES = 10.
- Reset, then idle for 64 cycles → AN walks FE, FD, … 7F every 8 cycles; SEG stays 7'h7F; grant = 0.
- req[2] pulses high at cycle 5 → grant = 4'b0100 at cycle 6; frame 32'h0000_1234 appears on digits 0–3. With dp_mask[3] set, DP = 0 only while AN = F7.
- Owner req[2] held; req[0] rises at hold cycle 3 → grant stays 0100 until hold cycle 10, then becomes 0001 one cycle later.
- Owner req[1] drops in the same cycle req[3] is high → grant goes 0010 → 1000 with no all-zero cycle.
- With SEG7_ARB_ROUND_ROBIN_EN defined, req = 4'b1111 held → grant sequence 0001, 0010, 0100, 1000, 0001, one step every 11 cycles.
- rst pulsed while granted in OPEN → grant = 0, AN = FF and SEG = 7F asynchronously; after release, the first grant follows the req rule.
